// File: rtl/ws2811_pkg.sv
package ws2811_pkg;

  localparam int unsigned WORD_W       = 24;
  localparam int unsigned PIX_W        = 10;
  localparam int unsigned HCNT_W       = 8;
  localparam int unsigned LCNT_W       = 12;
  localparam int unsigned BCNT_W       = 5;

  localparam int unsigned T_MIN_DEF    = 5;
  localparam int unsigned T_THRESH_DEF = 30;
  localparam int unsigned T_MAXH_DEF   = 100;
  localparam int unsigned T_RESET_DEF  = 2500;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_WAITLOW
  } rx_state_e;

endpackage

// File: rtl/ws2811_sync.sv
module ws2811_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic din_s,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchronizer; [2] is the previous din_s for edge detection.
  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign din_s = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ws2811_rx.sv
module ws2811_rx
  import ws2811_pkg::*;
#(
  parameter int unsigned T_MIN    = T_MIN_DEF,
  parameter int unsigned T_THRESH = T_THRESH_DEF,
  parameter int unsigned T_MAXH   = T_MAXH_DEF,
  parameter int unsigned T_RESET  = T_RESET_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_end,
  output logic [PIX_W-1:0]  pixel_count,
  output logic              error
);

  logic din_s;
  logic rise;
  logic fall;

  ws2811_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .din_s (din_s),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e           state_q, state_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d, hcnt_inc;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d, lcnt_inc;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   sr_q, sr_d, shifted;
  logic [WORD_W-1:0]   data_out_q, data_out_d;
  logic [PIX_W-1:0]    pix_q, pix_d;
  logic                data_valid_q, data_valid_d;
  logic                frame_end_q, frame_end_d;
  logic                error_q, error_d;
  logic                new_bit;

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    lcnt_d       = lcnt_q;
    bit_cnt_d    = bit_cnt_q;
    sr_d         = sr_q;
    data_out_d   = data_out_q;
    pix_d        = pix_q;
    data_valid_d = 1'b0;
    frame_end_d  = 1'b0;
    error_d      = 1'b0;

    hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + 1'b1;
    lcnt_inc = (lcnt_q == '1) ? lcnt_q : lcnt_q + 1'b1;
    new_bit  = (hcnt_q >= HCNT_W'(T_THRESH));
    shifted  = {sr_q[WORD_W-2:0], new_bit};

    // Frame bookkeeping clears one cycle after the frame_end pulse.
    if (frame_end_q) begin
      bit_cnt_d = '0;
      sr_d      = '0;
      pix_d     = '0;
    end

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hcnt_d  = '0;
          lcnt_d  = '0;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          lcnt_d  = '0;
          if (hcnt_q < HCNT_W'(T_MIN)) begin
            error_d = 1'b1;
          end else if (bit_cnt_q == BCNT_W'(WORD_W - 1)) begin
            sr_d         = '0;
            bit_cnt_d    = '0;
            data_out_d   = shifted;
            data_valid_d = 1'b1;
            pix_d        = (pix_q == '1) ? pix_q : pix_q + 1'b1;
          end else begin
            sr_d      = shifted;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (din_s) begin
          hcnt_d = hcnt_inc;
          if (hcnt_inc == HCNT_W'(T_MAXH)) begin
            error_d   = 1'b1;
            sr_d      = '0;
            bit_cnt_d = '0;
            state_d   = ST_WAITLOW;
          end
        end
      end

      ST_WAITLOW: begin
        if (fall) begin
          state_d = ST_LOW;
          lcnt_d  = '0;
        end
      end

      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          hcnt_d  = '0;
          lcnt_d  = '0;
        end else if (!din_s) begin
          lcnt_d = lcnt_inc;
          if (lcnt_inc == LCNT_W'(T_RESET)) begin
            frame_end_d = 1'b1;
            error_d     = (bit_cnt_q != '0);
            lcnt_d      = '0;
            state_d     = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= '0;
      lcnt_q       <= '0;
      bit_cnt_q    <= '0;
      sr_q         <= '0;
      data_out_q   <= '0;
      pix_q        <= '0;
      data_valid_q <= 1'b0;
      frame_end_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      lcnt_q       <= lcnt_d;
      bit_cnt_q    <= bit_cnt_d;
      sr_q         <= sr_d;
      data_out_q   <= data_out_d;
      pix_q        <= pix_d;
      data_valid_q <= data_valid_d;
      frame_end_q  <= frame_end_d;
      error_q      <= error_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_end   = frame_end_q;
  assign pixel_count = pix_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ws2811_rx.sv
module tb_ws2811_rx;
  import ws2811_pkg::*;

  localparam int unsigned TMIN  = T_MIN_DEF;
  localparam int unsigned TTHR  = T_THRESH_DEF;
  localparam int unsigned TMAXH = T_MAXH_DEF;
  localparam int unsigned TRST  = T_RESET_DEF;

  if (!(TMIN < TTHR && TTHR < TMAXH && TMAXH < TRST)) begin : g_order_bad
    $fatal(1, "timing parameters out of order");
  end

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic [23:0] data_out;
  logic        data_valid;
  logic        frame_end;
  logic [9:0]  pixel_count;
  logic        error;

  ws2811_rx #(
    .T_MIN    (TMIN),
    .T_THRESH (TTHR),
    .T_MAXH   (TMAXH),
    .T_RESET  (TRST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .frame_end   (frame_end),
    .pixel_count (pixel_count),
    .error       (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [23:0] dout;
    logic        dv;
    logic        fe;
    logic [9:0]  pc;
    logic        er;
  } exp_t;

  exp_t        ring [8];
  int unsigned cyc = 0;
  int unsigned nvec = 0;
  int unsigned nfail = 0;

  // Model state: pulse-width view of the raw line.
  logic [23:0] m_do = '0;
  logic [23:0] m_bits = '0;
  logic [9:0]  m_pc = '0;
  int unsigned m_nbits = 0;
  bit          prev = 1'b0;
  int unsigned hi_run = 0;
  int unsigned lo_run = 0;
  bit          armed = 1'b0;
  bit          ignore_hi = 1'b0;
  bit          clr_pend = 1'b0;

  int unsigned dv_cnt = 0, fe_cnt = 0, er_cnt = 0, fe_er_cnt = 0;
  logic [23:0] dv_log [$];

  task automatic model_step(input bit d, input bit r);
    bit dv, fe, er;
    dv = 1'b0; fe = 1'b0; er = 1'b0;
    if (r) begin
      m_do = '0; m_bits = '0; m_pc = '0; m_nbits = 0; prev = 1'b0;
      hi_run = 0; lo_run = 0; armed = 1'b0; ignore_hi = 1'b0; clr_pend = 1'b0;
      for (int unsigned i = 1; i <= 3; i++) ring[(cyc + i) % 8] = '0;
      return;
    end
    if (clr_pend) begin
      m_pc = '0; m_nbits = 0; m_bits = '0; clr_pend = 1'b0;
    end
    if (d) begin
      hi_run = prev ? hi_run + 1 : 1;
      if (!ignore_hi && hi_run == TMAXH + 1) begin
        er = 1'b1; m_nbits = 0; m_bits = '0; ignore_hi = 1'b1;
      end
    end else if (prev) begin
      if (!ignore_hi) begin
        if (hi_run - 1 < TMIN) begin
          er = 1'b1;
        end else begin
          m_bits = {m_bits[22:0], (hi_run - 1 >= TTHR)};
          m_nbits++;
          if (m_nbits == 24) begin
            m_do = m_bits; dv = 1'b1; m_nbits = 0;
            if (m_pc != 10'd1023) m_pc = m_pc + 10'd1;
          end
        end
      end
      ignore_hi = 1'b0; lo_run = 0; armed = 1'b1;
    end else if (armed) begin
      lo_run++;
      if (lo_run == TRST) begin
        fe = 1'b1; er = (m_nbits != 0);
        m_nbits = 0; m_bits = '0; armed = 1'b0; clr_pend = 1'b1;
      end
    end
    prev = d;
    ring[(cyc + 3) % 8] = '{dout: m_do, dv: dv, fe: fe, pc: m_pc, er: er};
  endtask

  task automatic tick(input bit d, input bit r);
    exp_t got, want;
    @(posedge clk);
    #1;
    cyc++;
    din = d;
    rst = r;
    model_step(d, r);
    @(negedge clk);
    got  = '{dout: data_out, dv: data_valid, fe: frame_end, pc: pixel_count, er: error};
    want = ring[cyc % 8];
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL cycle %0d outputs: got do=%h dv=%b fe=%b pc=%0d err=%b, want do=%h dv=%b fe=%b pc=%0d err=%b",
               cyc, got.dout, got.dv, got.fe, got.pc, got.er,
               want.dout, want.dv, want.fe, want.pc, want.er);
    end
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_log.push_back(data_out);
    end
    if (frame_end === 1'b1) fe_cnt++;
    if (error === 1'b1) er_cnt++;
    if (frame_end === 1'b1 && error === 1'b1) fe_er_cnt++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic idle_low(input int unsigned n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [23:0] w, input int unsigned nbits,
                           input bit rnd, input int unsigned glitch_after);
    for (int unsigned i = 0; i < nbits; i++) begin
      logic        b;
      int unsigned hi, lo;
      b = w[23 - i];
      if (rnd) begin
        hi = b ? $urandom_range(70, 36) : $urandom_range(25, 8);
        lo = $urandom_range(30, 8);
      end else begin
        hi = b ? 40 : 15;
        lo = 62 - hi;
      end
      repeat (hi) tick(1'b1, 1'b0);
      repeat (lo) tick(1'b0, 1'b0);
      if (glitch_after != 0 && i + 1 == glitch_after) begin
        repeat (3) tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);
      end
    end
  endtask

  int unsigned b_dv, b_fe, b_er, b_fe_er, b_log;

  task automatic mark();
    b_dv = dv_cnt; b_fe = fe_cnt; b_er = er_cnt; b_fe_er = fe_er_cnt; b_log = dv_log.size();
  endtask

  initial begin
    for (int unsigned i = 0; i < 8; i++) ring[i] = '0;
    repeat (4) tick(1'b0, 1'b1);
    idle_low(5);
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_pixel_count", 32'(pixel_count), 32'd0);
    chk("reset_pulses", 32'({data_valid, frame_end, error}), 32'd0);

    // Single word then gap
    mark();
    send_word(24'hA5C30F, 24, 1'b0, 0);
    chk("w1_pixel_count_before_gap", 32'(pixel_count), 32'd1);
    idle_low(2600);
    chk("w1_data_out", 32'(data_out), 32'h00A5C30F);
    chk("w1_model_word", 32'(m_do), 32'h00A5C30F);
    chk("w1_valid_count", dv_cnt - b_dv, 32'd1);
    chk("w1_frame_end_count", fe_cnt - b_fe, 32'd1);
    chk("w1_error_count", er_cnt - b_er, 32'd0);
    chk("w1_pixel_count_after_gap", 32'(pixel_count), 32'd0);

    // Three back-to-back words
    mark();
    send_word(24'hFF0000, 24, 1'b0, 0);
    send_word(24'h00FF00, 24, 1'b0, 0);
    send_word(24'h0000FF, 24, 1'b0, 0);
    chk("w3_pixel_count_before_gap", 32'(pixel_count), 32'd3);
    idle_low(2600);
    chk("w3_valid_count", dv_cnt - b_dv, 32'd3);
    chk("w3_word0", 32'(dv_log[b_log]), 32'h00FF0000);
    chk("w3_word1", 32'(dv_log[b_log + 1]), 32'h0000FF00);
    chk("w3_word2", 32'(dv_log[b_log + 2]), 32'h000000FF);
    chk("w3_pixel_count_after_gap", 32'(pixel_count), 32'd0);

    // Partial word at frame end
    mark();
    send_word(24'h3C5A99, 10, 1'b1, 0);
    idle_low(2600);
    chk("partial_frame_end", fe_cnt - b_fe, 32'd1);
    chk("partial_error", er_cnt - b_er, 32'd1);
    chk("partial_same_cycle", fe_er_cnt - b_fe_er, 32'd1);
    chk("partial_no_valid", dv_cnt - b_dv, 32'd0);

    // Glitch between bits 5 and 6
    mark();
    send_word(24'h5A3C96, 24, 1'b0, 5);
    idle_low(2600);
    chk("glitch_error", er_cnt - b_er, 32'd2 - 32'd1);
    chk("glitch_valid", dv_cnt - b_dv, 32'd1);
    chk("glitch_data_out", 32'(data_out), 32'h005A3C96);

    // Over-long high, then a clean word
    mark();
    repeat (150) tick(1'b1, 1'b0);
    idle_low(30);
    chk("overlong_error", er_cnt - b_er, 32'd1);
    chk("overlong_no_valid", dv_cnt - b_dv, 32'd0);
    send_word(24'h123456, 24, 1'b0, 0);
    idle_low(2600);
    chk("overlong_next_word", 32'(data_out), 32'h00123456);
    chk("overlong_valid", dv_cnt - b_dv, 32'd1);

    // Reset mid-word
    send_word(24'hC0FFEE, 12, 1'b0, 0);
    mark();
    tick(1'b0, 1'b1);
    idle_low(5);
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_pixel_count", 32'(pixel_count), 32'd0);
    chk("rst_no_pulses", (dv_cnt - b_dv) + (fe_cnt - b_fe) + (er_cnt - b_er), 32'd0);
    send_word(24'h0F1E2D, 24, 1'b0, 0);
    chk("rst_next_word", 32'(data_out), 32'h000F1E2D);
    chk("rst_next_pixel_count", 32'(pixel_count), 32'd1);
    idle_low(2600);

    // Randomized frames
    for (int unsigned f = 0; f < 3; f++) begin
      int unsigned nw;
      nw = $urandom_range(3, 1);
      for (int unsigned k = 0; k < nw; k++) begin
        logic [31:0] w;
        int unsigned ga;
        w  = $urandom;
        ga = ($urandom_range(3, 0) == 0) ? $urandom_range(23, 1) : 0;
        send_word(w[23:0], 24, 1'b1, ga);
      end
      if (f == 1) begin
        logic [31:0] wp;
        wp = $urandom;
        send_word(wp[23:0], $urandom_range(23, 1), 1'b1, 0);
      end
      idle_low(2600);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
